wbu: RTL and testbench
======================

WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter RESET_MSTATUS, default 32'h0000_1800, reset value of mstatus.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have in_valid  in  1  LSU result valid; in_ready  out  1  WBU can accept.
REQ-004 SHALL have alu_out  in  32  ALU result / load address; pc_next  in  32  next PC.
REQ-005 SHALL have reg_write  in  1; wb_addr  in  5; mem_read  in  1; func3  in  3; mem_rdata  in  32  raw load word.
REQ-006 SHALL have zicsr  in  1; csr_rdata  in  32; din_mstatus/din_mtvec/din_mepc/din_mcause  in  32 each; wen_mstatus/wen_mtvec/wen_mepc/wen_mcause  in  1 each.
REQ-007 SHALL have rs1_addr, rs2_addr  in  5; rs1_data, rs2_data  out  32  combinational RF reads.
REQ-008 SHALL have mtvec_o, mepc_o, mstatus_o, mcause_o  out  32  current CSR values; pc_o  out  32  committed next PC; wb_done  out  1  commit pulse to controller.

Function
REQ-009 SHALL implement FSM IDLE, COMMIT; in_ready = (state==IDLE).
REQ-010 SHALL, on in_valid&in_ready at an edge, latch all data inputs and enter COMMIT; in_valid in COMMIT is ignored.
REQ-011 SHALL hold wb_done=1 exactly during COMMIT (one cycle) and return to IDLE at the next edge.
REQ-012 SHALL perform RF and CSR writes at the edge ending COMMIT; latency accept-edge to write-edge = 1 cycle.
REQ-013 SHALL select writeback data: mem_read ? load_data : zicsr ? csr_rdata : alu_out (priority in that order).
REQ-014 SHALL form load_data from latched alu_out[1:0]: LB/LBU (000/100) byte at offset [1:0]; LH/LHU (001/101) halfword at alu_out[1] (bit0 ignored); LW (010) full word; other func3 -> full word.
REQ-015 SHALL sign-extend LB/LH, zero-extend LBU/LHU to 32 bits.
REQ-016 SHALL ignore RF writes to x0; x0 reads always return 0.
REQ-017 SHALL write each CSR independently from its wen_*/din_*; simultaneous CSR and RF writes all take effect at the same edge.
REQ-018 SHALL return the pre-write value for RF reads during COMMIT (no bypass).
REQ-019 SHALL update pc_o with latched pc_next at the edge ending COMMIT.

Reset
REQ-020 SHALL, on rst, force state=IDLE, wb_done=0, in_ready=1 after release, pc_o=0, all RF entries 0, mstatus=RESET_MSTATUS, mtvec/mepc/mcause=0.
REQ-021 SHALL, on rst asserted during COMMIT, abort with no RF/CSR/pc_o write.

Configuration
REQ-022 SHALL, with WBU_RV32E_EN defined, implement 16 registers: writes with wb_addr[4]=1 dropped, reads with addr[4]=1 return 0.
REQ-023 SHALL, without WBU_RV32E_EN, implement 32 registers x0-x31.

Structure
REQ-024 SHALL take func3 load encodings, FSM state enum and CSR reset constants from shared package wbu_pkg.
REQ-025 SHALL place register file in sub-module wbu_regfile (one write port, two async read ports, async reset).

Verification
REQ-026 LW: alu_out=0x8000_0004, mem_rdata=0xDEAD_BEEF, wb_addr=5 -> wb_done one cycle later, x5=0xDEAD_BEEF.
REQ-027 LB/LBU: mem_rdata=0x0080_7F00, alu_out[1:0]=2 -> LB gives 0xFFFF_FF80, LBU gives 0x0000_0080; LH alu_out[1]=1 -> 0x0000_0080.
REQ-028 Write to x0 with alu_out=0x1234 -> rs1_addr=0 reads 0; x1 unchanged.
REQ-029 CSR trap: zicsr=1, wen_mepc=wen_mcause=1, din_mepc=0x8000_0100, din_mcause=11, csr_rdata=0x55, wb_addr=3 -> mepc_o/mcause_o updated, x3=0x55 at same edge.
REQ-030 Back-to-back in_valid held high -> accepts every other cycle, in_ready low in COMMIT; rst asserted in COMMIT -> no write, RF all 0, mstatus_o=0x1800.
REQ-031 With WBU_RV32E_EN: write wb_addr=17 -> dropped, read x17 returns 0; x1 write still works.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back unit: FSM states, load func3
// encodings, CSR reset constants, register-file geometry and the load
// alignment helper.
// Build option: WBU_RV32E_EN selects the 16-entry RV32E register file
// (default build: 32 entries, x0-x31).
package wbu_pkg;

    // Write-back FSM: one accept cycle in IDLE, one commit cycle.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } wbu_state_e;

    // Load width/sign encodings carried on func3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // CSR reset values (mstatus default: MPP = machine mode).
    localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;
    localparam logic [31:0] MTVEC_RST   = 32'h0000_0000;
    localparam logic [31:0] MEPC_RST    = 32'h0000_0000;
    localparam logic [31:0] MCAUSE_RST  = 32'h0000_0000;

    // Register-file depth; higher addresses read as zero and drop writes.
`ifdef WBU_RV32E_EN
    localparam int NUM_REGS = 16;
`else
    localparam int NUM_REGS = 32;
`endif
    localparam int REG_AW = $clog2(NUM_REGS);

    // Everything captured at the accept edge and consumed during COMMIT.
    typedef struct packed {
        logic        reg_write;
        logic [4:0]  wb_addr;
        logic        mem_read;
        logic [2:0]  func3;
        logic [31:0] alu_out;
        logic [31:0] pc_next;
        logic [31:0] mem_rdata;
        logic        zicsr;
        logic [31:0] csr_rdata;
        logic [31:0] din_mstatus;
        logic [31:0] din_mtvec;
        logic [31:0] din_mepc;
        logic [31:0] din_mcause;
        logic        wen_mstatus;
        logic        wen_mtvec;
        logic        wen_mepc;
        logic        wen_mcause;
    } wbu_txn_t;

    // Extract and extend the addressed byte/halfword of a raw load word.
    // Halfword selection uses off[1] only; unknown func3 returns the word.
    function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LBU:  r = {24'h0, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LHU:  r = {16'h0, h};
            F3_LW:   r = word;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wbu_regfile.sv
// Integer register file: one write port, two asynchronous read ports,
// asynchronous active-high reset clearing every entry.
// x0 is hard-wired to zero. Depth follows wbu_pkg::NUM_REGS, which the
// WBU_RV32E_EN build option reduces to 16; out-of-range writes are
// dropped and out-of-range reads return zero.
module wbu_regfile
    import wbu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [NUM_REGS];

    // True when the 5-bit address maps onto an implemented entry.
    function automatic logic in_range(input logic [4:0] a);
        return ((32'(a) >> REG_AW) == 32'd0);
    endfunction

    logic wr_ok;
    assign wr_ok = we_i && (waddr_i != 5'd0) && in_range(waddr_i);

    // Storage: cleared on reset, single write port otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[waddr_i[REG_AW-1:0]] <= wdata_i;
        end
    end

    // Read ports: no bypass of the write in flight; x0 and unimplemented
    // addresses read as zero.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if ((raddr1_i != 5'd0) && in_range(raddr1_i)) begin
            rdata1_o = regs_q[raddr1_i[REG_AW-1:0]];
        end
        if ((raddr2_i != 5'd0) && in_range(raddr2_i)) begin
            rdata2_o = regs_q[raddr2_i[REG_AW-1:0]];
        end
    end

endmodule

// File: rtl/wbu.sv
// Write-back unit: accepts one LSU/ALU/CSR result, holds it for a single
// COMMIT cycle (wb_done high), then writes the register file, the machine
// CSRs and the committed PC on the edge that ends COMMIT.
// Build option: WBU_RV32E_EN (see wbu_pkg) selects a 16-entry register file.
//
// Handshake: a transfer happens at a rising clk edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE and does not depend
// on in_valid, and in_valid is ignored while in_ready is low.
module wbu
    import wbu_pkg::*;
#(
    parameter logic [31:0] RESET_MSTATUS = MSTATUS_RST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_out,
    input  logic [31:0] pc_next,
    input  logic        reg_write,
    input  logic [4:0]  wb_addr,
    input  logic        mem_read,
    input  logic [2:0]  func3,
    input  logic [31:0] mem_rdata,
    input  logic        zicsr,
    input  logic [31:0] csr_rdata,
    input  logic [31:0] din_mstatus,
    input  logic [31:0] din_mtvec,
    input  logic [31:0] din_mepc,
    input  logic [31:0] din_mcause,
    input  logic        wen_mstatus,
    input  logic        wen_mtvec,
    input  logic        wen_mepc,
    input  logic        wen_mcause,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mstatus_o,
    output logic [31:0] mcause_o,
    output logic [31:0] pc_o,
    output logic        wb_done,
    output wbu_state_e  dbg_state_o
);

    wbu_state_e  state_q, state_d;
    wbu_txn_t    txn_q, txn_d;
    logic        accept;
    logic        commit;
    logic [31:0] load_data;
    logic [31:0] wb_data;
    logic        rf_we;

    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
    logic [31:0] pc_q;

    assign accept = in_valid && in_ready;
    assign commit = (state_q == ST_COMMIT);

    // Next state and handshake/commit outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        wb_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                wb_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gather the incoming transaction into one record.
    always_comb begin
        txn_d             = txn_q;
        txn_d.reg_write   = reg_write;
        txn_d.wb_addr     = wb_addr;
        txn_d.mem_read    = mem_read;
        txn_d.func3       = func3;
        txn_d.alu_out     = alu_out;
        txn_d.pc_next     = pc_next;
        txn_d.mem_rdata   = mem_rdata;
        txn_d.zicsr       = zicsr;
        txn_d.csr_rdata   = csr_rdata;
        txn_d.din_mstatus = din_mstatus;
        txn_d.din_mtvec   = din_mtvec;
        txn_d.din_mepc    = din_mepc;
        txn_d.din_mcause  = din_mcause;
        txn_d.wen_mstatus = wen_mstatus;
        txn_d.wen_mtvec   = wen_mtvec;
        txn_d.wen_mepc    = wen_mepc;
        txn_d.wen_mcause  = wen_mcause;
    end

    // Capture the transaction on the accept edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_q <= '0;
        end else if (accept) begin
            txn_q <= txn_d;
        end
    end

    // Writeback data select: load result, then CSR read value, then ALU.
    always_comb begin
        load_data = load_align(txn_q.func3, txn_q.alu_out[1:0], txn_q.mem_rdata);
        if (txn_q.mem_read) begin
            wb_data = load_data;
        end else if (txn_q.zicsr) begin
            wb_data = txn_q.csr_rdata;
        end else begin
            wb_data = txn_q.alu_out;
        end
    end

    assign rf_we = commit && txn_q.reg_write;

    wbu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (rf_we),
        .waddr_i  (txn_q.wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_addr),
        .rdata1_o (rs1_data),
        .raddr2_i (rs2_addr),
        .rdata2_o (rs2_data)
    );

    // Machine CSRs: each updated independently at the edge ending COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q <= RESET_MSTATUS;
            mtvec_q   <= MTVEC_RST;
            mepc_q    <= MEPC_RST;
            mcause_q  <= MCAUSE_RST;
        end else if (commit) begin
            if (txn_q.wen_mstatus) mstatus_q <= txn_q.din_mstatus;
            if (txn_q.wen_mtvec)   mtvec_q   <= txn_q.din_mtvec;
            if (txn_q.wen_mepc)    mepc_q    <= txn_q.din_mepc;
            if (txn_q.wen_mcause)  mcause_q  <= txn_q.din_mcause;
        end
    end

    // Committed PC follows the latched next-PC at the end of COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else if (commit) begin
            pc_q <= txn_q.pc_next;
        end
    end

    assign mstatus_o   = mstatus_q;
    assign mtvec_o     = mtvec_q;
    assign mepc_o      = mepc_q;
    assign mcause_o    = mcause_q;
    assign pc_o        = pc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wbu.sv
// Directed testbench for wbu: loads, CSR trap commit, x0 handling,
// back-to-back handshake, reset abort during COMMIT, RV32E option.
module tb_wbu;
    import wbu_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out, pc_next, mem_rdata, csr_rdata;
    logic        reg_write, mem_read, zicsr;
    logic [4:0]  wb_addr;
    logic [2:0]  func3;
    logic [31:0] din_mstatus, din_mtvec, din_mepc, din_mcause;
    logic        wen_mstatus, wen_mtvec, wen_mepc, wen_mcause;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] mtvec_o, mepc_o, mstatus_o, mcause_o, pc_o;
    logic        wb_done;
    wbu_state_e  dbg_state;

    always #5 clk = ~clk;

    wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .pc_next(pc_next), .reg_write(reg_write),
        .wb_addr(wb_addr), .mem_read(mem_read), .func3(func3),
        .mem_rdata(mem_rdata), .zicsr(zicsr), .csr_rdata(csr_rdata),
        .din_mstatus(din_mstatus), .din_mtvec(din_mtvec),
        .din_mepc(din_mepc), .din_mcause(din_mcause),
        .wen_mstatus(wen_mstatus), .wen_mtvec(wen_mtvec),
        .wen_mepc(wen_mepc), .wen_mcause(wen_mcause),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o),
        .mcause_o(mcause_o), .pc_o(pc_o), .wb_done(wb_done),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] model_rf [32];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic writable(input logic [4:0] a);
        logic ok;
        ok = (a != 5'd0);
`ifdef WBU_RV32E_EN
        if (a[4]) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return writable(a) ? model_rf[a] : 32'h0;
    endfunction

    // Independent load formatter: shift the word down, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sb, sh;
        sb = w >> (8 * off);
        sh = w >> (16 * off[1]);
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'h0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        m_mstatus = 32'h0000_1800;
        m_mtvec   = 32'h0;
        m_mepc    = 32'h0;
        m_mcause  = 32'h0;
        exp_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic clear_csr_inputs();
        wen_mstatus = 1'b0; wen_mtvec = 1'b0; wen_mepc = 1'b0; wen_mcause = 1'b0;
        din_mstatus = 32'h0; din_mtvec = 32'h0; din_mepc = 32'h0; din_mcause = 32'h0;
    endtask

    // ---------------- driver: one transaction, checked end to end ----------------
    task automatic send(input logic rw, input logic [4:0] wa, input logic mr,
                        input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] word, input logic zc,
                        input logic [31:0] crd, input logic [31:0] pcn);
        logic [31:0] e;
        logic [31:0] e_rf;
        int n;
        @(negedge clk);
        reg_write = rw; wb_addr = wa; mem_read = mr; func3 = f3;
        alu_out = alu; mem_rdata = word; zicsr = zc; csr_rdata = crd; pc_next = pcn;
        rs1_addr = wa;
        if (mr)      e = ref_load(f3, alu[1:0], word);
        else if (zc) e = crd;
        else         e = alu;
        exp_q.push_back(e);
        exp_pc_q.push_back(pcn);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n = 1;
        while (wb_done !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        // COMMIT cycle: nothing written yet.
        check("commit_wb_done", wb_done, 1'b1);
        check("commit_in_ready", in_ready, 1'b0);
        check("commit_rf_prewrite", rs1_data, model_rd(wa));
        check("commit_mepc_prewrite", mepc_o, m_mepc);
        check("commit_mcause_prewrite", mcause_o, m_mcause);
        @(negedge clk);
        e = exp_q.pop_front();
        if (rw && writable(wa)) model_rf[wa] = e;
        e_rf = model_rd(wa);
        if (wen_mstatus) m_mstatus = din_mstatus;
        if (wen_mtvec)   m_mtvec   = din_mtvec;
        if (wen_mepc)    m_mepc    = din_mepc;
        if (wen_mcause)  m_mcause  = din_mcause;
        check("rf_after_commit", rs1_data, e_rf);
        check("pc_after_commit", pc_o, exp_pc_q.pop_front());
        check("idle_wb_done", wb_done, 1'b0);
        check("idle_in_ready", in_ready, 1'b1);
        check("mstatus", mstatus_o, m_mstatus);
        check("mtvec", mtvec_o, m_mtvec);
        check("mepc", mepc_o, m_mepc);
        check("mcause", mcause_o, m_mcause);
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        rs2_addr = a;
        #1 check(tag, rs2_data, exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        logic [4:0]  ra;
        logic [31:0] rv;
        rst = 1'b1; in_valid = 1'b0;
        reg_write = 1'b0; wb_addr = 5'd0; mem_read = 1'b0; func3 = 3'b0;
        alu_out = 32'h0; pc_next = 32'h0; mem_rdata = 32'h0; zicsr = 1'b0; csr_rdata = 32'h0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        clear_csr_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_wb_done", wb_done, 1'b0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_mstatus", mstatus_o, 32'h0000_1800);
        check("rst_mtvec", mtvec_o, 32'h0);
        check("rst_mepc", mepc_o, 32'h0);
        check("rst_mcause", mcause_o, 32'h0);
        read_check("rst_x5", 5'd5, 32'h0);

        // LW
        send(1'b1, 5'd5, 1'b1, F3_LW, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0000_0104);
        read_check("lw_x5", 5'd5, 32'hDEAD_BEEF);

        // Byte / halfword loads
        send(1'b1, 5'd10, 1'b1, F3_LB,  32'h0000_1002, 32'h0080_7F00, 1'b0, 32'h0, 32'h108);
        send(1'b1, 5'd11, 1'b1, F3_LBU, 32'h0000_1002, 32'h0080_7F00, 1'b0, 32'h0, 32'h10C);
        send(1'b1, 5'd12, 1'b1, F3_LH,  32'h0000_1003, 32'h0080_7F00, 1'b0, 32'h0, 32'h110);
        send(1'b1, 5'd13, 1'b1, F3_LH,  32'h0000_1000, 32'h8000_8001, 1'b0, 32'h0, 32'h114);
        send(1'b1, 5'd14, 1'b1, F3_LHU, 32'h0000_1002, 32'h8001_0000, 1'b0, 32'h0, 32'h118);
        send(1'b1, 5'd15, 1'b1, F3_LBU, 32'h0000_1001, 32'h0000_A500, 1'b0, 32'h0, 32'h11C);
        send(1'b1, 5'd16, 1'b1, 3'b011, 32'h0000_1003, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h120);
        read_check("lb_x10",  5'd10, 32'hFFFF_FF80);
        read_check("lbu_x11", 5'd11, 32'h0000_0080);
        read_check("lh_x12",  5'd12, 32'h0000_0080);
        read_check("lh_x13",  5'd13, 32'hFFFF_8001);
        read_check("lhu_x14", 5'd14, 32'h0000_8001);
        read_check("lbu_x15", 5'd15, 32'h0000_00A5);
        read_check("f3_other_x16", 5'd16, 32'hCAFE_F00D);

        // Select priority: load beats CSR, CSR beats ALU
        send(1'b1, 5'd20, 1'b1, F3_LW, 32'h0000_2000, 32'h1111_2222, 1'b1, 32'h3333_4444, 32'h124);
        read_check("prio_load", 5'd20, 32'h1111_2222);
        send(1'b1, 5'd21, 1'b0, F3_LW, 32'h0000_5555, 32'h0, 1'b1, 32'h6666_7777, 32'h128);
        read_check("prio_csr", 5'd21, 32'h6666_7777);

        // x0 writes ignored, x1 unaffected
        send(1'b1, 5'd1, 1'b0, F3_LW, 32'h0000_0011, 32'h0, 1'b0, 32'h0, 32'h12C);
        send(1'b1, 5'd0, 1'b0, F3_LW, 32'h0000_1234, 32'h0, 1'b0, 32'h0, 32'h130);
        read_check("x0_reads_zero", 5'd0, 32'h0);
        read_check("x1_unchanged", 5'd1, 32'h0000_0011);

        // reg_write low: no RF change
        send(1'b0, 5'd1, 1'b0, F3_LW, 32'hBAD0_BAD0, 32'h0, 1'b0, 32'h0, 32'h134);
        read_check("no_rw_x1", 5'd1, 32'h0000_0011);

        // CSR trap commit together with an RF write
        @(negedge clk);
        wen_mepc = 1'b1; wen_mcause = 1'b1;
        din_mepc = 32'h8000_0100; din_mcause = 32'd11;
        send(1'b1, 5'd3, 1'b0, F3_LW, 32'h0000_0999, 32'h0, 1'b1, 32'h0000_0055, 32'h8000_0000);
        check("trap_mepc", mepc_o, 32'h8000_0100);
        check("trap_mcause", mcause_o, 32'd11);
        read_check("trap_x3", 5'd3, 32'h0000_0055);
        clear_csr_inputs();
        wen_mtvec = 1'b1; din_mtvec = 32'h0000_0400;
        wen_mstatus = 1'b1; din_mstatus = 32'h0000_0088;
        send(1'b0, 5'd0, 1'b0, F3_LW, 32'h0, 32'h0, 1'b0, 32'h0, 32'h8000_0004);
        clear_csr_inputs();

        // Random ALU writebacks
        for (int i = 0; i < 4; i++) begin
            ra = 5'($urandom_range(1, 31));
            rv = $urandom;
            send(1'b1, ra, 1'b0, F3_LW, rv, 32'h0, 1'b0, 32'h0, 32'h200 + 32'(i * 4));
        end

        // Back-to-back: in_valid held high, one accept every other cycle
        @(negedge clk);
        reg_write = 1'b1; wb_addr = 5'd7; mem_read = 1'b0; zicsr = 1'b0;
        alu_out = 32'h0000_0077; pc_next = 32'h0000_0300;
        in_valid = 1'b1;
        for (k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("b2b_wb_done", wb_done, (k % 2 == 1) ? 1'b1 : 1'b0);
            check("b2b_in_ready", in_ready, (k % 2 == 1) ? 1'b0 : 1'b1);
        end
        in_valid = 1'b0;
        model_rf[7] = 32'h0000_0077;
        read_check("b2b_x7", 5'd7, 32'h0000_0077);
        check("b2b_pc", pc_o, 32'h0000_0300);

        // Reset asserted during COMMIT aborts every write
        @(negedge clk);
        reg_write = 1'b1; wb_addr = 5'd9; alu_out = 32'h0000_0ABC; pc_next = 32'h0000_0400;
        wen_mstatus = 1'b1; din_mstatus = 32'h0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("abort_in_commit", wb_done, 1'b1);
        rst = 1'b1;
        #1 check("abort_wb_done_rst", wb_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        clear_csr_inputs();
        model_reset();
        @(negedge clk);
        check("abort_mstatus", mstatus_o, 32'h0000_1800);
        check("abort_pc", pc_o, 32'h0);
        check("abort_in_ready", in_ready, 1'b1);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            #1 check("abort_rf_zero", rs1_data, 32'h0);
        end

        // Register-file depth option
`ifdef WBU_RV32E_EN
        send(1'b1, 5'd17, 1'b0, F3_LW, 32'h0000_0099, 32'h0, 1'b0, 32'h0, 32'h500);
        read_check("rv32e_x17_zero", 5'd17, 32'h0);
        read_check("rv32e_x1_alias_clear", 5'd1, 32'h0);
        send(1'b1, 5'd1, 1'b0, F3_LW, 32'h0000_005A, 32'h0, 1'b0, 32'h0, 32'h504);
        read_check("rv32e_x1", 5'd1, 32'h0000_005A);
`else
        send(1'b1, 5'd17, 1'b0, F3_LW, 32'h0000_0099, 32'h0, 1'b0, 32'h0, 32'h500);
        read_check("rv32i_x17", 5'd17, 32'h0000_0099);
        read_check("rv32i_x1_clear", 5'd1, 32'h0);
        send(1'b1, 5'd31, 1'b0, F3_LW, 32'h0000_005A, 32'h0, 1'b0, 32'h0, 32'h504);
        read_check("rv32i_x31", 5'd31, 32'h0000_005A);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
